sec_alert_monitor: RTL and testbench
====================================

// Module: sec_alert_monitor
// PURPOSE
// - N-channel taint monitor for BOOM exec-unit ALU request ports (jmp, csr, extra ALUs).
// - Flags tainted control-flow uops (br/jal/jalr) and drives registered abort info to the ROB.
// - Logs each alert as a record in a FIFO drained through a valid/ready port; keeps
//   saturating statistics and a threshold-triggered lockdown flag.
// PARAMETERS
// - NUM_CH      2   monitored exec-unit channels (1..8)
// - ROB_IDX_W   6   ROB index width
// - YROT_W      6   yrot field width
// - FIFO_DEPTH  4   alert-log depth, power of two >=2
// - CNT_W       16  statistics counter width
// PORTS
// - clock            in   1                 sole clock
// - reset_n          in   1                 async active-low reset
// - ch_valid         in   NUM_CH            per-channel io_req_valid
// - ch_taint         in   NUM_CH            uop taint bit
// - ch_is_br/jal/jalr in  NUM_CH each       uop control-flow class
// - ch_rob_idx       in   NUM_CH*ROB_IDX_W  packed, ch0 in LSBs
// - ch_yrot          in   NUM_CH*YROT_W     packed, ch0 in LSBs
// - cfg_enable       in   1                 0: no alerts, no logging
// - cfg_type_en      in   3                 {jalr,jal,br} class enables
// - cfg_threshold    in   CNT_W             lockdown threshold; 0 = lockdown disabled
// - flush            in   1                 pipeline flush: kill pending alerts and log
// - lock_clr         in   1                 leave lockdown
// - alert_valid      out  1                 any channel alerted (registered)
// - alert_mask       out  NUM_CH            per-channel alert (registered)
// - abort_valid      out  NUM_CH            = alert_mask
// - abort_rob_idx    out  NUM_CH*ROB_IDX_W  rob_idx of alerting uop, else 0
// - abort_yrot       out  NUM_CH*YROT_W     yrot of alerting uop, else 0
// - log_valid        out  1                 FIFO non-empty
// - log_ready        in   1                 consumer accepts head record
// - log_ch           out  $clog2(NUM_CH)+1  channel of head record
// - log_rob_idx      out  ROB_IDX_W         head record rob_idx
// - log_yrot         out  YROT_W            head record yrot
// - log_overflow     out  1                 sticky: record lost (FIFO full or same-cycle loser)
// - alert_cnt        out  CNT_W             saturating count of alerting channel-cycles
// - drop_cnt         out  CNT_W             saturating count of lost records
// - locked           out  1                 lockdown state
// BEHAVIOUR
// - hit[i] = cfg_enable & ch_valid[i] & ch_taint[i] &
//   |({ch_is_jalr[i],ch_is_jal[i],ch_is_br[i]} & cfg_type_en).
// - Abort outputs: 1-cycle latency; registered from hit and channel fields; 0 when no hit.
// - flush high: abort regs load 0 next cycle, no alert counted or logged that cycle,
//   FIFO emptied (occupancy 0, pointers 0).
// - Log enqueue: at most one record/cycle = lowest-index hit. Each other hit that cycle
//   is lost: drop_cnt += (#hits-1), log_overflow set.
// - Full FIFO: enqueue accepted only if log_ready pops same cycle (pop-then-push);
//   otherwise that record is also lost (drop_cnt += 1, log_overflow set).
// - Empty FIFO: no same-cycle bypass; record visible next cycle. log_valid=0 -> outputs 0.
// - Pointers wrap modulo FIFO_DEPTH; occupancy counter spans 0..FIFO_DEPTH.
// - alert_cnt += popcount(hit) unless flush; saturates at all-ones. drop_cnt saturates too.
// - FSM MONITOR->LOCKED when cfg_threshold!=0 and alert_cnt (updated value) >= cfg_threshold.
// - FSM LOCKED->MONITOR on lock_clr; lock_clr also zeroes alert_cnt, drop_cnt, log_overflow.
//   Same-cycle hits are then counted from 0.
// - LOCKED: alerts, aborts and logging keep working; locked=1.
// - Reset (async assert, sync deassert in harness): all outputs 0, FIFO empty, FSM MONITOR.
//   Mid-operation reset discards queued records.
// STRUCTURE
// - sec_mon_pkg: alert record typedef {ch, rob_idx, yrot}, FSM state enum
//   (MONITOR=0, LOCKED=1), saturating-add function.
// - Sub-module sec_alert_fifo: parametrised sync FIFO, push/pop/flush, full/empty/count.
// - Top: hit logic, priority encoder, abort regs, counters, FSM.
// TESTING
// - ch0 tainted br, cfg_type_en=7 -> next cycle alert_mask=01, abort_rob_idx0=in; log ch0 rec.
// - ch0+ch1 hit same cycle -> mask=11; ch0 logged; drop_cnt=1; log_overflow=1.
// - log_ready=0, 5 single hits, depth 4 -> 4 logged, drop_cnt=1; then pop+push when full
//   -> no drop.
// - cfg_type_en=3'b001, tainted jal -> no alert; untainted br -> no alert; cfg_enable=0
//   -> none.
// - cfg_threshold=3, 3 hits -> locked=1 next cycle; lock_clr -> locked=0, counters 0.
// - flush with FIFO at 3 and hit pending -> next cycle log_valid=0, alert_valid=0, cnt
//   unchanged; reset_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/sec_mon_pkg.sv
// Shared types for the taint alert monitor: alert log record, FSM state, saturating add.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package sec_mon_pkg;

    // Record fields are sized for the largest supported configuration
    // (NUM_CH up to 8, ROB index and yrot up to 16 bits each).
    localparam int REC_CH_W   = 4;
    localparam int REC_ROB_W  = 16;
    localparam int REC_YROT_W = 16;

    typedef struct packed {
        logic [REC_CH_W-1:0]   ch;
        logic [REC_ROB_W-1:0]  rob_idx;
        logic [REC_YROT_W-1:0] yrot;
    } alert_rec_t;

    typedef enum logic {
        MONITOR = 1'b0,
        LOCKED  = 1'b1
    } mon_state_t;

    // a + b clamped to the all-ones value of a w-bit counter (w < 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [64:0] sum;
        max_v = (64'd1 << w) - 64'd1;
        sum   = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/sec_alert_fifo.sv
// Synchronous FIFO with flush; write-to-read latency 1 cycle (no empty bypass).
// Latency: pushed word visible at the head on the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle (pop-then-push).
module sec_alert_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Next pointers/occupancy; a pop frees the slot a same-cycle push may then use.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    // Storage, pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sec_alert_monitor.sv
// Taint monitor over N exec-unit request ports: registered abort info, alert log, stats, lockdown.
// Latency: abort/alert outputs 1 cycle after the request; log record visible 1 cycle after the hit.
// Backpressure: log drained by log_valid/log_ready; records that find no room are counted as drops.
module sec_alert_monitor
    import sec_mon_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ROB_IDX_W  = 6,
    parameter int YROT_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int LOG_CH_W  = $clog2(NUM_CH) + 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH-1:0]             ch_taint,
    input  logic [NUM_CH-1:0]             ch_is_br,
    input  logic [NUM_CH-1:0]             ch_is_jal,
    input  logic [NUM_CH-1:0]             ch_is_jalr,
    input  logic [NUM_CH*ROB_IDX_W-1:0]   ch_rob_idx,
    input  logic [NUM_CH*YROT_W-1:0]      ch_yrot,
    input  logic                          cfg_enable,
    input  logic [2:0]                    cfg_type_en,
    input  logic [CNT_W-1:0]              cfg_threshold,
    input  logic                          flush,
    input  logic                          lock_clr,
    output logic                          alert_valid,
    output logic [NUM_CH-1:0]             alert_mask,
    output logic [NUM_CH-1:0]             abort_valid,
    output logic [NUM_CH*ROB_IDX_W-1:0]   abort_rob_idx,
    output logic [NUM_CH*YROT_W-1:0]      abort_yrot,
    output logic                          log_valid,
    input  logic                          log_ready,
    output logic [LOG_CH_W-1:0]           log_ch,
    output logic [ROB_IDX_W-1:0]          log_rob_idx,
    output logic [YROT_W-1:0]             log_yrot,
    output logic                          log_overflow,
    output logic [CNT_W-1:0]              alert_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic                          locked
);

    localparam int HIT_W = 4;  // holds a hit count up to 8 channels plus one FIFO loss
    localparam int REC_W = $bits(alert_rec_t);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0]           hit;
    logic [NUM_CH-1:0]           hit_eff;
    logic [HIT_W-1:0]            n_hits;
    logic [HIT_W-1:0]            lost;
    alert_rec_t                  enq_rec;
    alert_rec_t                  head_rec;
    logic                        log_push;
    logic                        log_pop;
    logic                        push_lost;
    logic [REC_W-1:0]            fifo_pop_dat;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [OCC_W-1:0]            fifo_count;
    logic                        unused_fifo_bits;

    logic                        alert_valid_q, alert_valid_d;
    logic [NUM_CH-1:0]           alert_mask_q, alert_mask_d;
    logic [NUM_CH*ROB_IDX_W-1:0] abort_rob_q, abort_rob_d;
    logic [NUM_CH*YROT_W-1:0]    abort_yrot_q, abort_yrot_d;
    logic [CNT_W-1:0]            alert_cnt_q, alert_cnt_d;
    logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;
    logic                        log_overflow_q, log_overflow_d;
    mon_state_t                  state_q, state_d;

    // Per-channel hit: enabled, valid, tainted and of an enabled control-flow class.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = cfg_enable & ch_valid[i] & ch_taint[i] &
                     (|({ch_is_jalr[i], ch_is_jal[i], ch_is_br[i]} & cfg_type_en));
        end
        hit_eff = flush ? '0 : hit;
    end

    // Hit count and lowest-index hit selection for the single log slot per cycle.
    always_comb begin
        n_hits  = '0;
        enq_rec = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            n_hits = n_hits + HIT_W'(hit_eff[i]);
            if (hit_eff[i]) begin
                enq_rec.ch      = REC_CH_W'(i);
                enq_rec.rob_idx = REC_ROB_W'(ch_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]);
                enq_rec.yrot    = REC_YROT_W'(ch_yrot[i*YROT_W +: YROT_W]);
            end
        end
    end

    // Log enqueue/dequeue and loss accounting: extra hits lose, and a full FIFO without a pop loses.
    always_comb begin
        log_push  = |hit_eff;
        log_pop   = log_ready & ~fifo_empty;
        push_lost = log_push & fifo_full & ~log_pop;
        lost      = ((n_hits == '0) ? '0 : (n_hits - HIT_W'(1))) + HIT_W'(push_lost);
    end

    sec_alert_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (log_push),
        .push_dat (enq_rec),
        .pop      (log_pop),
        .flush    (flush),
        .pop_dat  (fifo_pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign head_rec         = alert_rec_t'(fifo_pop_dat);
    assign unused_fifo_bits = ^{fifo_pop_dat, fifo_count};
    assign log_valid        = ~fifo_empty;
    assign log_ch           = log_valid ? head_rec.ch[LOG_CH_W-1:0]       : '0;
    assign log_rob_idx      = log_valid ? head_rec.rob_idx[ROB_IDX_W-1:0] : '0;
    assign log_yrot         = log_valid ? head_rec.yrot[YROT_W-1:0]       : '0;

    // Abort info for the ROB: fields of alerting channels, zero elsewhere; flush kills it.
    always_comb begin
        alert_mask_d  = hit_eff;
        alert_valid_d = |hit_eff;
        abort_rob_d   = '0;
        abort_yrot_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_eff[i]) begin
                abort_rob_d[i*ROB_IDX_W +: ROB_IDX_W] = ch_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                abort_yrot_d[i*YROT_W +: YROT_W]      = ch_yrot[i*YROT_W +: YROT_W];
            end
        end
    end

    // Statistics: lock_clr zeroes first, so same-cycle hits and losses count from zero.
    always_comb begin
        alert_cnt_d    = CNT_W'(sat_add(64'(lock_clr ? '0 : alert_cnt_q), 64'(n_hits), CNT_W));
        drop_cnt_d     = CNT_W'(sat_add(64'(lock_clr ? '0 : drop_cnt_q), 64'(lost), CNT_W));
        log_overflow_d = (lock_clr ? 1'b0 : log_overflow_q) | (lost != '0);
    end

    // Lockdown FSM: trips on the updated alert count, leaves only on lock_clr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MONITOR: begin
                if ((cfg_threshold != '0) && (alert_cnt_d >= cfg_threshold)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (lock_clr) begin
                    state_d = MONITOR;
                end
            end
            default: state_d = MONITOR;
        endcase
    end

    // Output, statistics and FSM state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alert_valid_q  <= 1'b0;
            alert_mask_q   <= '0;
            abort_rob_q    <= '0;
            abort_yrot_q   <= '0;
            alert_cnt_q    <= '0;
            drop_cnt_q     <= '0;
            log_overflow_q <= 1'b0;
            state_q        <= MONITOR;
        end else begin
            alert_valid_q  <= alert_valid_d;
            alert_mask_q   <= alert_mask_d;
            abort_rob_q    <= abort_rob_d;
            abort_yrot_q   <= abort_yrot_d;
            alert_cnt_q    <= alert_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            log_overflow_q <= log_overflow_d;
            state_q        <= state_d;
        end
    end

    assign alert_valid   = alert_valid_q;
    assign alert_mask    = alert_mask_q;
    assign abort_valid   = alert_mask_q;
    assign abort_rob_idx = abort_rob_q;
    assign abort_yrot    = abort_yrot_q;
    assign alert_cnt     = alert_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign log_overflow  = log_overflow_q;
    assign locked        = (state_q == LOCKED);

endmodule

// File: tb/tb_sec_alert_monitor.sv
// Bench for sec_alert_monitor: directed scenarios plus random traffic against a queue-based model.
// Latency: expectations are queued per driven cycle and checked one edge later by a monitor.
// Backpressure: log_ready is driven both directed and random to exercise full/drop behaviour.
module tb_sec_alert_monitor;

    localparam int NUM_CH     = 2;
    localparam int ROB_IDX_W  = 6;
    localparam int YROT_W     = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 5;
    localparam int LCW        = $clog2(NUM_CH) + 1;
    localparam int RW         = NUM_CH * ROB_IDX_W;
    localparam int YW         = NUM_CH * YROT_W;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] ch_valid, ch_taint, ch_is_br, ch_is_jal, ch_is_jalr;
    logic [RW-1:0]     ch_rob_idx;
    logic [YW-1:0]     ch_yrot;
    logic              cfg_enable;
    logic [2:0]        cfg_type_en;
    logic [CNT_W-1:0]  cfg_threshold;
    logic              flush, lock_clr, log_ready;
    logic              alert_valid;
    logic [NUM_CH-1:0] alert_mask, abort_valid;
    logic [RW-1:0]     abort_rob_idx;
    logic [YW-1:0]     abort_yrot;
    logic              log_valid;
    logic [LCW-1:0]    log_ch;
    logic [ROB_IDX_W-1:0] log_rob_idx;
    logic [YROT_W-1:0] log_yrot;
    logic              log_overflow;
    logic [CNT_W-1:0]  alert_cnt, drop_cnt;
    logic              locked;

    sec_alert_monitor #(
        .NUM_CH(NUM_CH), .ROB_IDX_W(ROB_IDX_W), .YROT_W(YROT_W),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ch_valid(ch_valid), .ch_taint(ch_taint), .ch_is_br(ch_is_br),
        .ch_is_jal(ch_is_jal), .ch_is_jalr(ch_is_jalr),
        .ch_rob_idx(ch_rob_idx), .ch_yrot(ch_yrot),
        .cfg_enable(cfg_enable), .cfg_type_en(cfg_type_en), .cfg_threshold(cfg_threshold),
        .flush(flush), .lock_clr(lock_clr),
        .alert_valid(alert_valid), .alert_mask(alert_mask), .abort_valid(abort_valid),
        .abort_rob_idx(abort_rob_idx), .abort_yrot(abort_yrot),
        .log_valid(log_valid), .log_ready(log_ready), .log_ch(log_ch),
        .log_rob_idx(log_rob_idx), .log_yrot(log_yrot), .log_overflow(log_overflow),
        .alert_cnt(alert_cnt), .drop_cnt(drop_cnt), .locked(locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ch;
        int rob;
        int yrot;
    } rec_t;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic [RW-1:0]     rob;
        logic [YW-1:0]     yrot;
        logic              lv;
        int                lch;
        int                lrob;
        int                lyrot;
        logic              ovf;
        int                ac;
        int                dc;
        logic              lk;
    } exp_t;

    exp_t exp_q[$];
    rec_t mq[$];
    int   m_ac, m_dc;
    bit   m_ovf, m_lk;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ac  = 0;
        m_dc  = 0;
        m_ovf = 0;
        m_lk  = 0;
    endtask

    // Reference: what the outputs must look like after the coming clock edge.
    task automatic model_step();
        exp_t            e;
        bit [NUM_CH-1:0] h;
        int              n;
        int              lost;
        int              first;
        bit              pop;
        for (int i = 0; i < NUM_CH; i++) begin
            h[i] = cfg_enable && ch_valid[i] && ch_taint[i] &&
                   (({ch_is_jalr[i], ch_is_jal[i], ch_is_br[i]} & cfg_type_en) != 3'b000);
        end
        if (flush) h = '0;
        e.mask = h;
        e.rob  = '0;
        e.yrot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (h[i]) begin
                e.rob[i*ROB_IDX_W +: ROB_IDX_W] = ch_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                e.yrot[i*YROT_W +: YROT_W]      = ch_yrot[i*YROT_W +: YROT_W];
            end
        end
        n   = $countones(h);
        pop = log_ready && (mq.size() > 0);
        if (lock_clr) begin
            m_ac  = 0;
            m_dc  = 0;
            m_ovf = 0;
        end
        m_ac = (m_ac + n > CMAX) ? CMAX : m_ac + n;
        lost = (n > 0) ? n - 1 : 0;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (n > 0) begin
                first = -1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (h[i]) first = i;
                if (mq.size() < FIFO_DEPTH)
                    mq.push_back('{first, int'(ch_rob_idx[first*ROB_IDX_W +: ROB_IDX_W]),
                                   int'(ch_yrot[first*YROT_W +: YROT_W])});
                else
                    lost++;
            end
        end
        m_dc = (m_dc + lost > CMAX) ? CMAX : m_dc + lost;
        if (lost > 0) m_ovf = 1;
        if (m_lk) begin
            if (lock_clr) m_lk = 0;
        end else if (cfg_threshold != 0 && m_ac >= int'(cfg_threshold)) begin
            m_lk = 1;
        end
        e.lv    = mq.size() > 0;
        e.lch   = e.lv ? mq[0].ch : 0;
        e.lrob  = e.lv ? mq[0].rob : 0;
        e.lyrot = e.lv ? mq[0].yrot : 0;
        e.ovf   = m_ovf;
        e.ac    = m_ac;
        e.dc    = m_dc;
        e.lk    = m_lk;
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest queued expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alert_valid",   alert_valid, |e.mask);
            chk("alert_mask",    alert_mask, e.mask);
            chk("abort_valid",   abort_valid, e.mask);
            chk("abort_rob_idx", abort_rob_idx, e.rob);
            chk("abort_yrot",    abort_yrot, e.yrot);
            chk("log_valid",     log_valid, e.lv);
            chk("log_ch",        log_ch, e.lch);
            chk("log_rob_idx",   log_rob_idx, e.lrob);
            chk("log_yrot",      log_yrot, e.lyrot);
            chk("log_overflow",  log_overflow, e.ovf);
            chk("alert_cnt",     alert_cnt, e.ac);
            chk("drop_cnt",      drop_cnt, e.dc);
            chk("locked",        locked, e.lk);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_alert_valid"}, alert_valid, 0);
        chk({tag, "_alert_mask"}, alert_mask, 0);
        chk({tag, "_abort_rob"}, abort_rob_idx, 0);
        chk({tag, "_abort_yrot"}, abort_yrot, 0);
        chk({tag, "_log_valid"}, log_valid, 0);
        chk({tag, "_log_fields"}, {log_ch, log_rob_idx, log_yrot}, 0);
        chk({tag, "_overflow"}, log_overflow, 0);
        chk({tag, "_counters"}, {alert_cnt, drop_cnt}, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    task automatic idle();
        ch_valid   = '0;
        ch_taint   = '0;
        ch_is_br   = '0;
        ch_is_jal  = '0;
        ch_is_jalr = '0;
        ch_rob_idx = '0;
        ch_yrot    = '0;
        flush      = 1'b0;
        lock_clr   = 1'b0;
    endtask

    // cls = {jalr, jal, br}
    task automatic set_ch(input int i, input bit taint, input bit [2:0] cls,
                          input int rob, input int yr);
        ch_valid[i]   = 1'b1;
        ch_taint[i]   = taint;
        ch_is_br[i]   = cls[0];
        ch_is_jal[i]  = cls[1];
        ch_is_jalr[i] = cls[2];
        ch_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'(rob);
        ch_yrot[i*YROT_W +: YROT_W]          = YROT_W'(yr);
    endtask

    task automatic step();
        model_step();
        @(negedge clock);
    endtask

    initial begin
        reset_n       = 1'b0;
        idle();
        cfg_enable    = 1'b1;
        cfg_type_en   = 3'b111;
        cfg_threshold = '0;
        log_ready     = 1'b1;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Single tainted branch on ch0.
        idle(); set_ch(0, 1, 3'b001, 5, 9); step();
        chk("d1_mask", alert_mask, 2'b01);
        chk("d1_rob0", abort_rob_idx[ROB_IDX_W-1:0], 5);
        chk("d1_log", {log_valid, log_ch, log_rob_idx}, {1'b1, 2'd0, 6'd5});

        // Both channels hit: ch0 logged, ch1 lost.
        idle(); set_ch(0, 1, 3'b010, 11, 1); set_ch(1, 1, 3'b100, 22, 2); step();
        chk("d2_mask", alert_mask, 2'b11);
        chk("d2_drop", drop_cnt, 1);
        chk("d2_ovf", log_overflow, 1);
        idle(); lock_clr = 1'b1; step();

        // Fill the log with the consumer stalled, then pop+push on a full FIFO.
        log_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle(); set_ch(0, 1, 3'b001, 40 + k, k); step();
        end
        chk("d3_drop", drop_cnt, 1);
        chk("d3_head", log_rob_idx, 40);
        log_ready = 1'b1;
        idle(); set_ch(1, 1, 3'b001, 50, 3); step();
        chk("d3_nodrop", drop_cnt, 1);
        idle();
        repeat (4) step();
        chk("d3_drained", log_valid, 0);

        // Class filtering, taint and global enable.
        cfg_type_en = 3'b001;
        idle(); set_ch(0, 1, 3'b010, 7, 7); step();
        chk("d4_jal_off", alert_valid, 0);
        idle(); set_ch(0, 0, 3'b001, 7, 7); step();
        chk("d4_untainted", alert_valid, 0);
        cfg_type_en = 3'b111; cfg_enable = 1'b0;
        idle(); set_ch(0, 1, 3'b001, 7, 7); set_ch(1, 1, 3'b111, 8, 8); step();
        chk("d4_disabled", alert_valid, 0);
        cfg_enable = 1'b1;

        // Lockdown threshold.
        idle(); lock_clr = 1'b1; step();
        cfg_threshold = CNT_W'(3);
        for (int k = 0; k < 3; k++) begin
            idle(); set_ch(0, 1, 3'b001, k, k); step();
            if (k == 1) chk("d5_not_yet", locked, 0);
        end
        chk("d5_locked", locked, 1);
        idle(); lock_clr = 1'b1; step();
        chk("d5_unlocked", locked, 0);
        chk("d5_cnt_zero", {alert_cnt, drop_cnt, log_overflow}, 0);
        cfg_threshold = '0;

        // Flush with three queued records and a hit in flight.
        log_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle(); set_ch(1, 1, 3'b100, 30 + k, k); step();
        end
        idle(); set_ch(0, 1, 3'b001, 33, 3); flush = 1'b1; step();
        chk("d6_log_valid", log_valid, 0);
        chk("d6_alert", alert_valid, 0);
        chk("d6_cnt", alert_cnt, 3);

        // Saturation of both counters.
        idle(); lock_clr = 1'b1; step();
        for (int k = 0; k < 20; k++) begin
            idle(); set_ch(0, 1, 3'b001, k, k); set_ch(1, 1, 3'b010, k + 1, k); step();
        end
        chk("d7_alert_sat", alert_cnt, CMAX);
        chk("d7_drop_sat", drop_cnt, CMAX);
        log_ready = 1'b1;

        // Random traffic with one asynchronous reset mid-run.
        for (int c = 0; c < 500; c++) begin
            if (c == 250) begin
                #2 reset_n = 1'b0;
                #1 check_all_zero("midreset");
                model_reset();
                @(negedge clock);
                reset_n = 1'b1;
            end
            if (c % 100 == 0)
                cfg_threshold = ($urandom_range(0, 1) == 1) ? CNT_W'($urandom_range(1, 20)) : '0;
            ch_valid    = NUM_CH'($urandom);
            ch_taint    = NUM_CH'($urandom) | NUM_CH'($urandom);
            ch_is_br    = NUM_CH'($urandom);
            ch_is_jal   = NUM_CH'($urandom);
            ch_is_jalr  = NUM_CH'($urandom);
            ch_rob_idx  = RW'($urandom);
            ch_yrot     = YW'($urandom);
            cfg_enable  = ($urandom_range(0, 9) != 0);
            cfg_type_en = 3'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            lock_clr    = ($urandom_range(0, 19) == 0);
            log_ready   = 1'($urandom);
            step();
        end

        idle();
        step();
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
